// File: rtl/cpu_fetch_unit_if.sv
// Fetch-stage bus: instruction ROM port, decode handshake and redirect.
// The master modport is the fetch unit; the slave modport is ROM, decode and datapath.
interface cpu_fetch_unit_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              imem_rd;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_data;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              fetch_halted;

   modport master (
      output imem_rd, imem_addr, instr_valid, instr_out, instr_pc, fetch_halted,
      input  imem_data, instr_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_rd, imem_addr, instr_valid, instr_out, instr_pc, fetch_halted,
      output imem_data, instr_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch: owns the PC, reads the sync ROM and queues {instr, pc} in a prefetch FIFO.
// Latency: first instr_valid 3 cycles after reset release; 3 cycles from a redirect to its instr.
// Backpressure: reads issue only when FIFO + in-flight has room; FETCH_HALT_EN enables halt on 8'hFF.
module cpu_fetch_unit #(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 8,
   parameter int                FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input logic              clk,
   input logic              reset,
   cpu_fetch_unit_if.master bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] infl_addr;
   logic              infl;
   logic [DATA_W-1:0] mem_dat [FIFO_DEPTH];
   logic [ADDR_W-1:0] mem_pc  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              pop;
   logic              push;
   logic              issue;
   logic              halt_hit;
   logic [OCC_W-1:0]  occupancy;

   // A pop this cycle frees a slot, which is what lets the loop sustain one read per cycle.
   always_comb begin
      pop       = (count != '0) && bus.instr_ready;
      push      = infl && !bus.redirect;
      occupancy = {1'b0, count} + OCC_W'(infl) - OCC_W'(pop);
      issue     = (state == ST_RUN) && !bus.redirect && (occupancy < OCC_W'(FIFO_DEPTH));
`ifdef FETCH_HALT_EN
      halt_hit  = push && (bus.imem_data == {DATA_W{1'b1}});
`else
      halt_hit  = 1'b0;
`endif
   end

   assign bus.imem_rd     = issue;
   assign bus.imem_addr   = issue ? fetch_pc : '0;
   assign bus.instr_valid = (count != '0);
   assign bus.instr_out   = mem_dat[rd_ptr];
   assign bus.instr_pc    = mem_pc[rd_ptr];
`ifdef FETCH_HALT_EN
   assign bus.fetch_halted = (state == ST_HALT);
`else
   assign bus.fetch_halted = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_BOOT;
         fetch_pc  <= RESET_PC;
         infl_addr <= '0;
         infl      <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_dat[i] <= '0;
            mem_pc[i]  <= '0;
         end
      end else if (bus.redirect) begin
         // Flush everything, including a response arriving this cycle.
         state    <= ST_RUN;
         fetch_pc <= bus.redirect_pc;
         infl     <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            mem_dat[wr_ptr] <= bus.imem_data;
            mem_pc[wr_ptr]  <= infl_addr;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
         // A read issued alongside a halting push is for a later address and is dropped.
         infl  <= issue && !halt_hit;
         if (issue) begin
            infl_addr <= fetch_pc;
            fetch_pc  <= fetch_pc + 1'b1;
         end
         case (state)
            ST_BOOT: state <= ST_RUN;
            ST_RUN:  if (halt_hit) state <= ST_HALT;
            default: state <= state;
         endcase
      end
   end
endmodule
